// File: rtl/shared_sweep.sv
// Sweeps all 32 {m,a,b,c,d} vectors into the lab-1 `shared` add/sub unit,
// samples {s1,s0} after SETTLE+1 cycles and checks against a golden model.
// Ports: clk, rst (async, active-high), start; a,b,c,d,m stimulus out;
// s1,s0 response in; busy, done, pass, err_cnt[5:0], fail_idx[4:0],
// fail_val[1:0] results.
// Build option: SHARED_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first
// mismatch and holds the failing vector on the stimulus outputs.
module shared_sweep #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       m,
  input  logic       s1,
  input  logic       s0,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] err_cnt,
  output logic [4:0] fail_idx,
  output logic [1:0] fail_val
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CHECK,
    FIN
  } state_t;

  localparam logic [3:0] LAST = 4'(SETTLE - 1);

  state_t     state, state_n;
  logic [4:0] idx, idx_n;
  logic [3:0] cnt, cnt_n;
  logic [5:0] err_n;
  logic [4:0] fidx_n;
  logic [1:0] fval_n;

  logic [1:0] ab, cd, exp_val, obs;
  logic       mismatch;
  logic       last_vec;

  assign ab       = idx[3:2];
  assign cd       = idx[1:0];
  // 2-bit arithmetic wraps mod 4 on its own
  assign exp_val  = idx[4] ? (ab - cd) : (ab + cd);
  assign obs      = {s1, s0};
  assign mismatch = obs != exp_val;
  assign last_vec = idx == 5'd31;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    err_n   = err_cnt;
    fidx_n  = fail_idx;
    fval_n  = fail_val;
    unique case (state)
      IDLE, FIN: begin
        if (start) begin
          state_n = DRIVE;
          idx_n   = '0;
          cnt_n   = '0;
          err_n   = '0;
          fidx_n  = '0;
          fval_n  = '0;
        end
      end
      DRIVE: begin
        if (cnt == LAST) begin
          state_n = CHECK;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      CHECK: begin
        if (mismatch) begin
          err_n = err_cnt + 6'd1;
          if (err_cnt == 6'd0) begin
            fidx_n = idx;
            fval_n = obs;
          end
        end
`ifdef SHARED_SWEEP_STOP_ON_FAIL_EN
        if (mismatch || last_vec) begin
          state_n = FIN;
        end else begin
          idx_n   = idx + 5'd1;
          state_n = DRIVE;
        end
`else
        if (last_vec) begin
          state_n = FIN;
        end else begin
          idx_n   = idx + 5'd1;
          state_n = DRIVE;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      err_cnt  <= '0;
      fail_idx <= '0;
      fail_val <= '0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      cnt      <= cnt_n;
      err_cnt  <= err_n;
      fail_idx <= fidx_n;
      fail_val <= fval_n;
    end
  end

  assign {m, a, b, c, d} = idx;
  assign busy = (state == DRIVE) || (state == CHECK);
  assign done = state == FIN;
  assign pass = done && (err_cnt == 6'd0);

endmodule

// File: tb/tb_shared_sweep.sv
// Bench for shared_sweep: two instances (SETTLE=1 and SETTLE=3) against a
// cycle-count model of the sweep, with a fault table on the DUT response.
module tb_shared_sweep;

`ifdef SHARED_SWEEP_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [63:0] mask = '0;

  logic a1, b1, c1, d1, m1, s1_1, s0_1, busy1, done1, pass1;
  logic [5:0] err1;
  logic [4:0] fi1;
  logic [1:0] fv1;
  logic a3, b3, c3, d3, m3, s1_3, s0_3, busy3, done3, pass3;
  logic [5:0] err3;
  logic [4:0] fi3;
  logic [1:0] fv3;
  logic [4:0] st1, st3;

  int tests = 0;
  int fails = 0;
  int n1 = -1;
  int n3 = -1;
  logic [63:0] mk1 = '0;
  logic [63:0] mk3 = '0;

  always #5 clk = ~clk;

  function automatic int golden(input int j);
    int x, y;
    x = (j >> 2) & 3;
    y = j & 3;
    if (j >= 16) return (x - y + 4) % 4;
    return (x + y) % 4;
  endfunction

  function automatic int sweep_len(input logic [63:0] mk);
    if (STOP) begin
      for (int j = 0; j < 32; j++)
        if (mk[2*j +: 2] != 2'b00) return j + 1;
    end
    return 32;
  endfunction

  function automatic bit mbusy(input int n, input int s,
                               input logic [63:0] mk);
    return n >= 1 && n < 1 + sweep_len(mk) * (s + 1);
  endfunction

  assign st1 = {m1, a1, b1, c1, d1};
  assign st3 = {m3, a3, b3, c3, d3};
  assign {s1_1, s0_1} = 2'(golden(int'(st1))) ^ mask[{st1, 1'b0} +: 2];
  assign {s1_3, s0_3} = 2'(golden(int'(st3))) ^ mask[{st3, 1'b0} +: 2];

  shared_sweep #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start),
    .a(a1), .b(b1), .c(c1), .d(d1), .m(m1),
    .s1(s1_1), .s0(s0_1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .fail_idx(fi1), .fail_val(fv1)
  );

  shared_sweep #(.SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start),
    .a(a3), .b(b3), .c(c3), .d(d3), .m(m3),
    .s1(s1_3), .s0(s0_3),
    .busy(busy3), .done(done3), .pass(pass3),
    .err_cnt(err3), .fail_idx(fi3), .fail_val(fv3)
  );

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_inst(
    input string nm, input int s, input int n, input logic [63:0] mk,
    input logic bz, input logic dn, input logic ps,
    input logic [5:0] ec, input logic [4:0] fi, input logic [1:0] fv,
    input logic [4:0] st
  );
    int e_bz, e_dn, e_err, e_fi, e_fv, e_st, len, nck, k;
    e_bz = 0; e_dn = 0; e_err = 0; e_fi = 0; e_fv = 0; e_st = 0;
    if (n >= 1) begin
      len  = sweep_len(mk);
      e_bz = (n < 1 + len * (s + 1)) ? 1 : 0;
      e_dn = 1 - e_bz;
      k    = (n - 1) / (s + 1);
      nck  = (k > len) ? len : k;
      for (int j = 0; j < nck; j++) begin
        if (mk[2*j +: 2] != 2'b00) begin
          if (e_err == 0) begin
            e_fi = j;
            e_fv = golden(j) ^ int'(mk[2*j +: 2]);
          end
          e_err++;
        end
      end
      e_st = (k > len - 1) ? len - 1 : k;
    end
    chk({nm, ".busy"}, int'(bz), e_bz);
    chk({nm, ".done"}, int'(dn), e_dn);
    chk({nm, ".pass"}, int'(ps), (e_dn == 1 && e_err == 0) ? 1 : 0);
    chk({nm, ".err_cnt"}, int'(ec), e_err);
    chk({nm, ".fail_idx"}, int'(fi), e_fi);
    chk({nm, ".fail_val"}, int'(fv), e_fv);
    chk({nm, ".stim"}, int'(st), e_st);
  endtask

  // Model advance at each edge, then compare just after it.
  always @(posedge clk) begin
    if (rst) begin
      n1 = -1;
      n3 = -1;
    end else begin
      if (start && !mbusy(n1, 1, mk1)) begin
        n1 = 1;
        mk1 = mask;
      end else if (n1 >= 1 && n1 < 1000000) begin
        n1++;
      end
      if (start && !mbusy(n3, 3, mk3)) begin
        n3 = 1;
        mk3 = mask;
      end else if (n3 >= 1 && n3 < 1000000) begin
        n3++;
      end
    end
    #1;
    check_inst("s1", 1, n1, mk1, busy1, done1, pass1,
               err1, fi1, fv1, st1);
    check_inst("s3", 3, n3, mk3, busy3, done3, pass3,
               err3, fi3, fv3, st3);
  end

  task automatic wait_idle();
    int t;
    t = 0;
    while ((mbusy(n1, 1, mk1) || mbusy(n3, 3, mk3)) && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) begin
      fails++;
      tests++;
      $display("FAIL wait_idle: timeout after %0d cycles", t);
    end
  endtask

  function automatic logic [63:0] stuck_s0();
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < 32; j++)
      r[2*j +: 2] = {1'b0, 1'(golden(j) & 1)};
    return r;
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    chk("rst.busy", int'(busy1), 0);
    chk("rst.done", int'(done1), 0);
    chk("rst.stim", int'(st1), 0);
    rst = 1'b0;
    @(negedge clk);

    // correct DUT: done after edge k+65 (SETTLE=1), k+129 (SETTLE=3)
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("lit.busy_k1", int'(busy1), 1);
    repeat (63) @(negedge clk);
    chk("lit.done_k64", int'(done1), 0);
    @(negedge clk);
    chk("lit.done_k65", int'(done1), 1);
    chk("lit.pass_k65", int'(pass1), 1);
    chk("lit.stim_done", int'(st1), 31);
    repeat (63) @(negedge clk);
    chk("lit.done3_k128", int'(done3), 0);
    @(negedge clk);
    chk("lit.done3_k129", int'(done3), 1);
    chk("lit.pass3", int'(pass3), 1);

    // s0 stuck at 0
    mask = stuck_s0();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
`ifdef SHARED_SWEEP_STOP_ON_FAIL_EN
    chk("lit.stop_done5", int'(done1), 1);
    chk("lit.stop_err", int'(err1), 1);
    chk("lit.stop_stim", int'(st1), 1);
`else
    chk("lit.run_done5", int'(done1), 0);
`endif
    wait_idle();
`ifndef SHARED_SWEEP_STOP_ON_FAIL_EN
    chk("lit.stuck_err", int'(err1), 16);
`endif
    chk("lit.stuck_fidx", int'(fi1), 1);
    chk("lit.stuck_fval", int'(fv1), 0);
    chk("lit.stuck_pass", int'(pass1), 0);

    // restart from DONE clears the results
    mask = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("lit.re_err", int'(err1), 0);
    chk("lit.re_done", int'(done1), 0);
    chk("lit.re_stim", int'(st1), 0);
    wait_idle();

    // start held high during the sweep
    @(negedge clk);
    start = 1'b1;
    repeat (61) @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("lit.hold_done", int'(done1), 1);
    wait_idle();

    // async reset mid-sweep
    mask = stuck_s0();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("lit.arst_busy", int'(busy1), 0);
    chk("lit.arst_err", int'(err1), 0);
    chk("lit.arst_stim", int'(st1), 0);
    chk("lit.arst_fidx", int'(fi1), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // randomized rounds
    for (int r = 0; r < 8; r++) begin
      wait_idle();
      for (int j = 0; j < 32; j++)
        mask[2*j +: 2] = (r % 3 != 0 && $urandom_range(0, 3) == 0)
                         ? 2'($urandom_range(1, 3)) : 2'b00;
      for (int t = 0; t < 200; t++) begin
        if (!mbusy(n1, 1, mk1) && !mbusy(n3, 3, mk3))
          start = ($urandom_range(0, 3) == 0);
        else
          start = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 299) == 0) rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      start = 1'b0;
    end
    wait_idle();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
